// File: rtl/freq_meter.sv
// Gated frequency counter: counts rising edges of an asynchronous input over a
// fixed window of clk cycles. Define FREQ_METER_SAT_EN for a saturating counter with overflow flag.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             overflow,
  output logic             gate
);

  localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic {S_IDLE, S_GATE} state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             edge_det;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             fv_q, fv_d;
  logic             gate_c, win_end, win_run;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic inc);
`ifdef FREQ_METER_SAT_EN
    bump = (inc && !(&c)) ? c + CNT_W'(1) : c;
`else
    bump = c + CNT_W'(inc);
`endif
  endfunction

  // Synchronizer s1/s2 plus history s3 for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_det = s2_q & ~s3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // A window that reaches its last cycle completes even if enable has just dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable)  state_d = S_GATE;
      S_GATE:  if (!enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gate_c  = (state_q == S_GATE);
    win_end = gate_c && (gcnt_q == GATE_LAST);
    win_run = gate_c && enable && !win_end;
  end

  always_comb begin
    gcnt_d = '0;
    ecnt_d = '0;
    freq_d = freq_q;
    fv_d   = 1'b0;
    if (win_run) begin
      gcnt_d = gcnt_q + GW'(1);
      ecnt_d = bump(ecnt_q, edge_det);
    end
    if (win_end) begin
      freq_d = bump(ecnt_q, edge_det);
      fv_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt_q <= '0;
      ecnt_q <= '0;
      freq_q <= '0;
      fv_q   <= 1'b0;
    end else begin
      gcnt_q <= gcnt_d;
      ecnt_q <= ecnt_d;
      freq_q <= freq_d;
      fv_q   <= fv_d;
    end
  end

`ifdef FREQ_METER_SAT_EN
  logic wovf_q, wovf_d, ovf_q, ovf_d, wovf_fin;

  // Sticky per-window flag; includes a saturating edge in the final cycle
  assign wovf_fin = wovf_q | (edge_det & (&ecnt_q));

  always_comb begin
    wovf_d = win_run ? wovf_fin : 1'b0;
    ovf_d  = win_end ? wovf_fin : ovf_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wovf_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wovf_q <= wovf_d;
      ovf_q  <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign freq       = freq_q;
  assign freq_valid = fv_q;
  assign gate       = gate_c;

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated frequency counter, the measuring counterpart of the clock dividers: where a divider turns a known count of `clk` cycles into a slow tick, this block counts rising edges of an external, asynchronous signal over a fixed window of `clk` cycles. With defaults (50 MHz `clk`, 1 s gate) the result is the input frequency in Hz. Results go to the display/reporting logic as a registered value with a one-cycle valid strobe.

## Interface
- `GATE_CYCLES`, 50_000_000 — gate window length in `clk` cycles; minimum 2.
- `CNT_W`, 32 — width of the edge counter and result.
- `clk`  in  1 — system clock, 50 MHz nominal.
- `rst`  in  1 — reset; one clock, reset is asynchronous and active-high.
- `enable`  in  1 — measurement runs while high.
- `sig_in`  in  1 — signal to measure, asynchronous to `clk`.
- `freq`  out  CNT_W — edge count of the last completed gate window.
- `freq_valid`  out  1 — one-cycle strobe; `freq` updated this cycle.
- `overflow`  out  1 — the last completed window exceeded the `CNT_W` range; see Configuration.
- `gate`  out  1 — high while a window is open.

## Operation
- Input path: 2-FF synchronizer (`s1`, `s2`), then history FF `s3`. Edge is counted when `s2 & ~s3`. All three registers reset to 0.
- FSM states:
  - IDLE: `gate=0`; gate counter and edge counter held at 0. When `enable=1`, go to GATE next cycle.
  - GATE: `gate=1`. The gate counter increments from 0 to `GATE_CYCLES-1`. The edge counter increments on each detected edge.
- Window end, on the cycle with gate count `GATE_CYCLES-1`:
  - On the next edge, `freq` loads the final count. This includes any edge detected in that last cycle.
  - `freq_valid` pulses for 1 cycle.
  - Both counters clear.
  - If `enable` is still 1, the FSM stays in GATE and the next window starts with no dead cycle. Otherwise it goes to IDLE.
- `enable` falling mid-window: abort. Return to IDLE next cycle. No `freq_valid`; `freq` and `overflow` hold their last values.
- The edge counter is `CNT_W` bits. Overflow behaviour is set by Configuration.
- Reset (async, any state): state IDLE, all counters 0, `freq=0`, `freq_valid=0`, `overflow=0`, `gate=0`. Reset mid-window discards the partial count.
- Measurable input: high and low phases of at least 1 `clk` each. Maximum is `clk`/2. Faster inputs undercount; this is not flagged.

## Timing
- `sig_in` rise to edge-counted: 3 `clk` edges (`s1`, `s2`, then `s3` compare).
- Edges arriving within the last 2 cycles of a window are counted in the next window. This is inherent pipeline skew, constant across windows.
- `enable` rise to `gate=1`: 1 cycle.
- Window start (first GATE cycle) to `freq_valid`: exactly `GATE_CYCLES` cycles. Back-to-back strobes are `GATE_CYCLES` apart.
- `freq` and `overflow` update only in the `freq_valid` cycle and are stable otherwise.

## Configuration
- Macro `FREQ_METER_SAT_EN`.
- Defined:
  - The edge counter saturates at 2^CNT_W−1 and a sticky window-overflow bit is set.
  - At window end, `freq` loads the saturated value and `overflow` loads the window-overflow bit.
  - The window-overflow bit clears with the counters.
- Undefined:
  - The edge counter wraps modulo 2^CNT_W.
  - `overflow` is tied to 0.

## Test plan
All scenarios use `GATE_CYCLES=100` and `CNT_W=32` unless stated.
- Square wave, 5 clk high / 5 clk low, `enable` held high → `freq_valid` every 100 cycles, `freq=10` from the second window on.
- `sig_in` held constant at 1, then at 0 → `freq=0` every window; first window after a 0→1 step gives `freq=1`.
- `enable` dropped at gate count 50 → no `freq_valid`, `gate=0` next cycle, `freq` keeps prior value 10. Re-enable → next strobe 101 cycles after the `enable` rise.
- `CNT_W=3`, square wave period 4 clk (25 edges/window):
  - With `FREQ_METER_SAT_EN` → `freq=7`, `overflow=1`.
  - Without it → `freq=1` (25 mod 8), `overflow=0`.
- `rst` asserted asynchronously mid-window → outputs 0 immediately. After release with `enable=1`, first strobe arrives 101 cycles later with the correct count.
- Single `sig_in` pulse timed so its detected edge lands in window cycle 99 → counted in that window (`freq=1`). Same pulse detected 1 cycle later → counted in the next window.
